// File: rtl/pool_pkg.sv
// Shared types and helpers for the pool serializer.
// POOL_RELU_EN (when defined) clamps negative pooled words to zero.
package pool_pkg;
  typedef enum logic [0:0] {eIDLE = 1'b0, eSEND = 1'b1} state_e;

  localparam int MAX_WORD = 64;

  // Width-generic ReLU: the caller zero-extends its word and names its width.
  function automatic logic [MAX_WORD-1:0] relu(input logic [MAX_WORD-1:0] word, input int width);
    return word[6'(width-1)] ? '0 : word;
  endfunction
endpackage

// File: rtl/max_pool_unit.sv
// Combinational signed max over one pool group; ReLU on the result under POOL_RELU_EN.
module max_pool_unit
  import pool_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int POOL_SIZE = 2
) (
  input  logic [POOL_SIZE-1:0][WORD_SIZE-1:0] words,
  output logic [WORD_SIZE-1:0]                word
);
  logic [WORD_SIZE-1:0] best;

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    best = words[0];
    for (int i = 1; i < POOL_SIZE; i++)
      if ($signed(words[i]) > $signed(best)) best = words[i];
  end

`ifdef POOL_RELU_EN
  assign word = WORD_SIZE'(relu(MAX_WORD'(best), WORD_SIZE));
`else
  assign word = best;
`endif
endmodule

// File: rtl/pool_serializer.sv
// Captures a conv-result vector, max-pools it, and streams pooled words over valid/ready.
// Build option POOL_RELU_EN enables ReLU on every pooled word.
module pool_serializer
  import pool_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int WORD_SIZE  = 16,
  parameter int POOL_SIZE  = 2
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 valid_i,
  output logic                                 yumi_o,
  input  logic [NUM_INPUTS-1:0][WORD_SIZE-1:0] data_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [WORD_SIZE-1:0]                 data_o,
  output logic                                 last_o
);
  localparam int NUM_OUTPUTS = NUM_INPUTS / POOL_SIZE;
  localparam int IDX_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  state_e                                 state;
  logic [IDX_W-1:0]                       index;
  logic [IDX_W-1:0]                       next_idx;
  logic [NUM_OUTPUTS-1:0][WORD_SIZE-1:0]  pool_comb;
  logic [NUM_OUTPUTS-1:0][WORD_SIZE-1:0]  pooled;

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_pool
    max_pool_unit #(.WORD_SIZE(WORD_SIZE), .POOL_SIZE(POOL_SIZE)) u_pool (
      .words (data_i[g*POOL_SIZE +: POOL_SIZE]),
      .word  (pool_comb[g])
    );
  end

  assign yumi_o   = reset_i && valid_i && (state == eIDLE);
  assign next_idx = index + 1'b1;

  // Outputs are registered: the first word is loaded straight from the pool units
  // on acceptance so it is valid the cycle after yumi_o.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= eIDLE;
      index   <= '0;
      pooled  <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
    end else begin
      case (state)
        eSEND: begin
          if (ready_i) begin
            if (last_o) begin
              state   <= eIDLE;
              index   <= '0;
              valid_o <= 1'b0;
              data_o  <= '0;
              last_o  <= 1'b0;
            end else begin
              index  <= next_idx;
              data_o <= pooled[next_idx];
              last_o <= (next_idx == IDX_W'(NUM_OUTPUTS-1));
            end
          end
        end
        default: begin
          state <= eIDLE;
          if (valid_i) begin
            state   <= eSEND;
            index   <= '0;
            pooled  <= pool_comb;
            valid_o <= 1'b1;
            data_o  <= pool_comb[0];
            last_o  <= (NUM_OUTPUTS == 1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pool_serializer.sv
// Directed bench: 4-input/pool-2 instance plus a 2-input pass-through (pool-1) instance.
module tb_pool_serializer;
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic              valid_i, yumi_o, valid_o, ready_i, last_o;
  logic [3:0][15:0]  data_i;
  logic [15:0]       data_o;

  logic              v1, y1, vo1, r1, l1;
  logic [1:0][15:0]  d1;
  logic [15:0]       do1;

  int checks = 0;
  int errors = 0;

`ifdef POOL_RELU_EN
  localparam logic [15:0] NEG_W0 = 16'h0000;
  localparam logic [15:0] P1_W1  = 16'h0000;
`else
  localparam logic [15:0] NEG_W0 = 16'hFF00;
  localparam logic [15:0] P1_W1  = 16'h8001;
`endif

  pool_serializer #(.NUM_INPUTS(4), .WORD_SIZE(16), .POOL_SIZE(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .yumi_o(yumi_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o)
  );

  pool_serializer #(.NUM_INPUTS(2), .WORD_SIZE(16), .POOL_SIZE(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(v1), .yumi_o(y1), .data_i(d1),
    .valid_o(vo1), .ready_i(r1), .data_o(do1), .last_o(l1)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1; data_i = '0;
    v1 = 1'b1; r1 = 1'b1; d1 = '0;
    #12;
    checks++; if ({yumi_o, valid_o, last_o, data_o} !== 19'h0) begin
      errors++; $display("FAIL reset_main: got %h expected %h", {yumi_o, valid_o, last_o, data_o}, 19'h0); end
    checks++; if ({y1, vo1, l1, do1} !== 19'h0) begin
      errors++; $display("FAIL reset_pool1: got %h expected %h", {y1, vo1, l1, do1}, 19'h0); end
    valid_i = 1'b0; v1 = 1'b0;
    #2 reset_i = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ready_i = 1'b1; valid_i = 1'b1;
    data_i = {16'h0200, 16'h0080, 16'hFF00, 16'h0100};
    #1;
    checks++; if (yumi_o !== 1'b1) begin
      errors++; $display("FAIL basic_yumi: got %b expected 1", yumi_o); end
    step(); valid_i = 1'b0;
    checks++; if ({valid_o, last_o, data_o} !== {2'b10, 16'h0100}) begin
      errors++; $display("FAIL basic_w0: got %h expected %h", {valid_o, last_o, data_o}, {2'b10, 16'h0100}); end
    step();
    checks++; if ({valid_o, last_o, data_o} !== {2'b11, 16'h0200}) begin
      errors++; $display("FAIL basic_w1: got %h expected %h", {valid_o, last_o, data_o}, {2'b11, 16'h0200}); end
    step();
    checks++; if (valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got %b expected 0", valid_o); end
  endtask

  task automatic test_negative();
    ready_i = 1'b1; valid_i = 1'b1;
    data_i = {16'h7FFF, 16'h0005, 16'hFE00, 16'hFF00};
    step(); valid_i = 1'b0;
    checks++; if ({valid_o, last_o, data_o} !== {2'b10, NEG_W0}) begin
      errors++; $display("FAIL neg_w0: got %h expected %h", {valid_o, last_o, data_o}, {2'b10, NEG_W0}); end
    step();
    checks++; if ({valid_o, last_o, data_o} !== {2'b11, 16'h7FFF}) begin
      errors++; $display("FAIL neg_w1: got %h expected %h", {valid_o, last_o, data_o}, {2'b11, 16'h7FFF}); end
    step();
  endtask

  task automatic test_stall();
    ready_i = 1'b0; valid_i = 1'b1;
    data_i = {16'h0200, 16'h0080, 16'hFF00, 16'h0100};
    step();
    data_i = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 5; i++) begin
      checks++; if ({yumi_o, valid_o, last_o, data_o} !== {3'b010, 16'h0100}) begin
        errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, {yumi_o, valid_o, last_o, data_o}, {3'b010, 16'h0100}); end
      step();
    end
    ready_i = 1'b1; valid_i = 1'b0;
    step();
    checks++; if ({valid_o, last_o, data_o} !== {2'b11, 16'h0200}) begin
      errors++; $display("FAIL stall_w1: got %h expected %h", {valid_o, last_o, data_o}, {2'b11, 16'h0200}); end
    step();
    checks++; if (valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_idle: got %b expected 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1; valid_i = 1'b1;
    data_i = {16'h0010, 16'h0011, 16'h0003, 16'hFFFF};
    #1;
    checks++; if (yumi_o !== 1'b1) begin
      errors++; $display("FAIL b2b_yumi_a: got %b expected 1", yumi_o); end
    step();
    data_i = {16'h8000, 16'h7FFF, 16'h0001, 16'h0001};
    #1;
    checks++; if ({yumi_o, valid_o, last_o, data_o} !== {3'b010, 16'h0003}) begin
      errors++; $display("FAIL b2b_a0: got %h expected %h", {yumi_o, valid_o, last_o, data_o}, {3'b010, 16'h0003}); end
    step();
    checks++; if ({yumi_o, valid_o, last_o, data_o} !== {3'b011, 16'h0011}) begin
      errors++; $display("FAIL b2b_a1: got %h expected %h", {yumi_o, valid_o, last_o, data_o}, {3'b011, 16'h0011}); end
    step();
    checks++; if ({yumi_o, valid_o} !== 2'b10) begin
      errors++; $display("FAIL b2b_gap: got %b expected 10", {yumi_o, valid_o}); end
    step(); valid_i = 1'b0;
    checks++; if ({valid_o, last_o, data_o} !== {2'b10, 16'h0001}) begin
      errors++; $display("FAIL b2b_b0: got %h expected %h", {valid_o, last_o, data_o}, {2'b10, 16'h0001}); end
    step();
    checks++; if ({valid_o, last_o, data_o} !== {2'b11, 16'h7FFF}) begin
      errors++; $display("FAIL b2b_b1: got %h expected %h", {valid_o, last_o, data_o}, {2'b11, 16'h7FFF}); end
    step();
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b1; valid_i = 1'b1;
    data_i = {16'h0200, 16'h0080, 16'hFF00, 16'h0100};
    step(); valid_i = 1'b0;
    step(); ready_i = 1'b0;
    #2 reset_i = 1'b0; valid_i = 1'b1;
    #1;
    checks++; if ({yumi_o, valid_o, last_o, data_o} !== 19'h0) begin
      errors++; $display("FAIL midreset_async: got %h expected %h", {yumi_o, valid_o, last_o, data_o}, 19'h0); end
    valid_i = 1'b0;
    #2 reset_i = 1'b1;
    step();
    checks++; if (valid_o !== 1'b0) begin
      errors++; $display("FAIL midreset_stale: got %b expected 0", valid_o); end
    valid_i = 1'b1; ready_i = 1'b1;
    data_i = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    #1;
    checks++; if (yumi_o !== 1'b1) begin
      errors++; $display("FAIL midreset_yumi: got %b expected 1", yumi_o); end
    step(); valid_i = 1'b0;
    checks++; if ({valid_o, last_o, data_o} !== {2'b10, 16'h0020}) begin
      errors++; $display("FAIL midreset_w0: got %h expected %h", {valid_o, last_o, data_o}, {2'b10, 16'h0020}); end
    step();
    checks++; if ({valid_o, last_o, data_o} !== {2'b11, 16'h0040}) begin
      errors++; $display("FAIL midreset_w1: got %h expected %h", {valid_o, last_o, data_o}, {2'b11, 16'h0040}); end
    step();
  endtask

  task automatic test_pool1();
    r1 = 1'b1; v1 = 1'b1;
    d1 = {16'h8001, 16'h1234};
    #1;
    checks++; if (y1 !== 1'b1) begin
      errors++; $display("FAIL pool1_yumi: got %b expected 1", y1); end
    step(); v1 = 1'b0;
    checks++; if ({vo1, l1, do1} !== {2'b10, 16'h1234}) begin
      errors++; $display("FAIL pool1_w0: got %h expected %h", {vo1, l1, do1}, {2'b10, 16'h1234}); end
    step();
    checks++; if ({vo1, l1, do1} !== {2'b11, P1_W1}) begin
      errors++; $display("FAIL pool1_w1: got %h expected %h", {vo1, l1, do1}, {2'b11, P1_W1}); end
    step();
    checks++; if (vo1 !== 1'b0) begin
      errors++; $display("FAIL pool1_idle: got %b expected 0", vo1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_pool1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
